disp_scan: RTL and testbench

Time-multiplexed scanner for an N-digit common-anode seven-segment display. It snapshots a packed hex value and cycles through the digits at a fixed refresh rate. Each slot it presents one nibble to the downstream `disp_dec` segment decoder, along with the matching active-low anode enable. Value updates are applied only at frame boundaries, so the display never tears. Optional leading-zero blanking and inter-digit guard time suppress ghosting.

---
 rtl/disp_scan.sv | 106 ++++++++++
 tb/tb_disp_scan.sv | 133 +++++++++++++
 2 files changed

// File: rtl/disp_scan.sv
// Time-multiplexed scanner for an N-digit common-anode seven-segment display.
// A value is promoted into the displayed register only at frame wrap, so a frame never tears.
module disp_scan #(
    parameter  int N_DIG       = 4,
    parameter  int REFRESH_DIV = 50000,
    parameter  int GUARD       = 8,
    localparam int DW          = $clog2(N_DIG),
    localparam int PW          = $clog2(REFRESH_DIV)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [4*N_DIG-1:0] value_i,
    input  logic               blank_lz_i,
    output logic [3:0]         nib_o,
    output logic [N_DIG-1:0]   an_o,
    output logic               blank_o,
    output logic [DW-1:0]      dig_idx_o,
    output logic               frame_done_o
);

    logic [PW-1:0]      presc_q, presc_d;
    logic [DW-1:0]      dig_q, dig_d;
    logic [4*N_DIG-1:0] pend_q, pend_d, active_q, active_d;
    logic               pend_v_q, pend_v_d;
    logic [3:0]         nib_q, nib_d;
    logic [N_DIG-1:0]   an_q, an_d, lz;
    logic               blank_q, blank_d, run;
    logic               tc, last, wrap;

    assign tc   = (presc_q == PW'(REFRESH_DIV - 1));
    assign last = (dig_q == DW'(N_DIG - 1));
    assign wrap = tc && last;

    always_comb begin
        presc_d  = tc ? '0 : presc_q + 1'b1;
        dig_d    = dig_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        active_d = active_q;
        if (tc) dig_d = last ? '0 : dig_q + 1'b1;
        if (load_i) begin
            pend_d   = value_i;
            pend_v_d = 1'b1;
        end
        // A load landing on the wrap cycle goes straight to the display.
        if (wrap) begin
            if (load_i) begin
                active_d = value_i;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                active_d = pend_q;
                pend_v_d = 1'b0;
            end
        end
    end

    // lz[i]: digits i..N_DIG-1 of the next displayed value are all zero; digit 0 always shows.
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = N_DIG - 1; i > 0; i--) begin
            run   = run && (active_d[4*i +: 4] == 4'h0);
            lz[i] = run;
        end
    end

    always_comb begin
        nib_d   = active_d[{dig_d, 2'b00} +: 4];
        an_d    = '1;
        blank_d = 1'b1;
        if (int'(presc_d) >= GUARD && !(blank_lz_i && lz[dig_d])) begin
            an_d[dig_d] = 1'b0;
            blank_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q  <= '0;
            dig_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            active_q <= '0;
            nib_q    <= '0;
            an_q     <= '1;
            blank_q  <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            dig_q    <= dig_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            active_q <= active_d;
            nib_q    <= nib_d;
            an_q     <= an_d;
            blank_q  <= blank_d;
        end
    end

    assign nib_o        = nib_q;
    assign an_o         = an_q;
    assign blank_o      = blank_q;
    assign dig_idx_o    = dig_q;
    assign frame_done_o = wrap && !rst_i;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with N_DIG=4, REFRESH_DIV=4, GUARD=1.
// Outputs are sampled and inputs driven on the falling edge.
module tb_disp_scan;

    logic        clk = 1'b0;
    logic        rst, load, blank_lz;
    logic [15:0] value;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        blank;
    logic [1:0]  dig_idx;
    logic        frame_done;
    int          n_run = 0;
    int          n_fail = 0;
    int          cnt;

    always #5 clk = ~clk;

    disp_scan #(.N_DIG(4), .REFRESH_DIV(4), .GUARD(1)) dut (
        .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value), .blank_lz_i(blank_lz),
        .nib_o(nib), .an_o(an), .blank_o(blank), .dig_idx_o(dig_idx), .frame_done_o(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for the frame_done observation; n = cycles waited.
    task automatic wait_fd(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                n = i;
                break;
            end
        end
        chk("fd_timeout", (n != 0), 1);
    endtask

    task automatic reset_obs(input string tag);
        @(negedge clk);
        chk({tag, "_an"}, an, 4'hF);
        chk({tag, "_blank"}, blank, 1);
        chk({tag, "_nib"}, nib, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_dig"}, dig_idx, 0);
    endtask

    task automatic first_slot(input string tag);
        @(negedge clk);
        chk({tag, "_an"}, an, 4'hE);
        chk({tag, "_nib"}, nib, 0);
        chk({tag, "_blank"}, blank, 0);
        chk({tag, "_dig"}, dig_idx, 0);
    endtask

    // Checks one full frame starting right after a frame_done observation.
    // nibs/ans pack the per-slot nibble and enabled anode pattern, slot 0 in bits 3:0.
    task automatic check_frame(input string tag, input logic [15:0] nibs, input logic [15:0] ans,
                               input int ld_at, input logic [15:0] ld_val,
                               input int ld2_at, input logic [15:0] ld2_val,
                               input int lz_at, input logic lz_val);
        logic [15:0] nv, av;
        logic [3:0]  exp_an;
        nv = nibs;
        av = ans;
        for (int j = 1; j <= 16; j++) begin
            int s, p;
            @(negedge clk);
            s = (j - 1) / 4;
            p = (j - 1) % 4;
            exp_an = (p == 0) ? 4'hF : av[s*4 +: 4];
            chk($sformatf("%s_nib_j%0d", tag, j), nib, nv[s*4 +: 4]);
            chk($sformatf("%s_an_j%0d", tag, j), an, exp_an);
            chk($sformatf("%s_blank_j%0d", tag, j), blank, (exp_an == 4'hF));
            chk($sformatf("%s_dig_j%0d", tag, j), dig_idx, s);
            chk($sformatf("%s_fd_j%0d", tag, j), frame_done, (j == 16));
            load = 1'b0;
            if (j == ld_at) begin
                load  = 1'b1;
                value = ld_val;
            end
            if (j == ld2_at) begin
                load  = 1'b1;
                value = ld2_val;
            end
            if (j == lz_at) blank_lz = lz_val;
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; blank_lz = 1'b0; value = '0;
        for (int i = 0; i < 3; i++) reset_obs("rst0");
        rst = 1'b0;
        first_slot("rel0");
        load = 1'b1; value = 16'h12AF;
        @(negedge clk);
        load = 1'b0;
        wait_fd(cnt);
        chk("first_wrap_cycles", cnt, 13);

        check_frame("scan", 16'h12AF, 16'h7BDE, 6, 16'h1111, 0, 0, 0, 0);
        check_frame("upd1", 16'h1111, 16'h7BDE, 3, 16'h2222, 10, 16'h3333, 0, 0);
        check_frame("upd3", 16'h3333, 16'h7BDE, 8, 16'h5555, 16, 16'hBEEF, 0, 0);
        check_frame("wrapld", 16'hBEEF, 16'h7BDE, 0, 0, 0, 0, 0, 0);
        check_frame("nostale", 16'hBEEF, 16'h7BDE, 4, 16'h00A0, 0, 0, 2, 1'b1);
        check_frame("lz00a0", 16'h00A0, 16'hFFDE, 4, 16'h0000, 0, 0, 0, 0);
        check_frame("lz0000", 16'h0000, 16'h7BFE, 0, 0, 0, 0, 8, 1'b0);

        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            load = (j == 2);
            if (j == 2) value = 16'h9999;
        end
        rst = 1'b1;
        reset_obs("rst1");
        reset_obs("rst1");
        rst = 1'b0;
        first_slot("rel1");
        wait_fd(cnt);
        chk("rst_wrap_cycles", cnt, 14);
        check_frame("postrst", 16'h0000, 16'h7BDE, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
